// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-wide RAM controller: FSM states, access sizes, helpers.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_RD   = 2'd1,
    CTRL_WR   = 2'd2,
    CTRL_DONE = 2'd3
  } ctrl_state_t;

  localparam logic [1:0]  MEM_BYTE  = 2'b00;
  localparam logic [1:0]  MEM_HALF  = 2'b01;
  localparam logic [1:0]  MEM_WORD  = 2'b10;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Size code 2'b11 is deliberately folded into the word case.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates a byte-wide synchronous RAM between instruction fetch and load/store,
// serialising 1/2/4-byte accesses into byte cycles with little-endian assembly.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ack,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              ram_we,
  input  logic [7:0]        ram_din,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises req and holds it (with stable address/data) until it sees
  // its one-cycle ack; the request is latched at the accepting edge, so later changes are ignored.

  ctrl_state_t       state, state_next;
  logic [2:0]        cnt;
  logic              owner_if;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q, asm_q, if_inst_q, mem_rdata_q;
  logic [2:0]        nbytes;
  logic [4:0]        last_sh, cnt_sh;
  logic [31:0]       read_word;
  logic              read_done, flush_abort;
  logic              unused_addr_hi;

  assign nbytes         = size_bytes(size_q);
  assign last_sh        = {cnt[1:0] - 2'd1, 3'b000};
  assign cnt_sh         = {cnt[1:0], 3'b000};
  assign read_word      = asm_q | ({24'h0, ram_din} << last_sh);
  assign flush_abort    = owner_if && if_flush;
  assign unused_addr_hi = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CTRL_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ram_addr   = '0;
    ram_dout   = 8'h00;
    ram_we     = 1'b0;
    read_done  = 1'b0;
    case (state)
      CTRL_IDLE: begin
        if (mem_req)                  state_next = mem_we ? CTRL_WR : CTRL_RD;
        else if (if_req && !if_flush) state_next = CTRL_RD;
      end
      CTRL_RD: begin
        if (cnt < nbytes) ram_addr = base_q + ADDR_W'(cnt);
        if (flush_abort) state_next = CTRL_IDLE;
        else if (cnt == nbytes) begin
          state_next = CTRL_DONE;
          read_done  = 1'b1;
        end
      end
      CTRL_WR: begin
        ram_we   = 1'b1;
        ram_addr = base_q + ADDR_W'(cnt);
        ram_dout = wdata_q[cnt_sh +: 8];
        if (cnt == nbytes - 3'd1) state_next = CTRL_DONE;
      end
      CTRL_DONE: state_next = CTRL_IDLE;
      default:   state_next = CTRL_IDLE;
    endcase
  end

  // RAM read data lags the address by one cycle, so byte cnt-1 arrives while cnt is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 3'd0;
      owner_if    <= 1'b0;
      size_q      <= MEM_BYTE;
      base_q      <= '0;
      wdata_q     <= ZERO_WORD;
      asm_q       <= ZERO_WORD;
      if_inst_q   <= ZERO_WORD;
      mem_rdata_q <= ZERO_WORD;
    end else begin
      case (state)
        CTRL_IDLE: begin
          cnt   <= 3'd0;
          asm_q <= ZERO_WORD;
          if (mem_req) begin
            owner_if <= 1'b0;
            base_q   <= mem_addr[ADDR_W-1:0];
            size_q   <= mem_size;
            wdata_q  <= mem_wdata;
          end else if (if_req && !if_flush) begin
            owner_if <= 1'b1;
            base_q   <= if_addr[ADDR_W-1:0];
            size_q   <= MEM_WORD;
          end
        end
        CTRL_RD: begin
          if (state_next == CTRL_RD) begin
            if (cnt != 3'd0) asm_q[last_sh +: 8] <= ram_din;
            cnt <= cnt + 3'd1;
          end else begin
            cnt <= 3'd0;
          end
          if (read_done) begin
            if (owner_if) if_inst_q   <= read_word;
            else          mem_rdata_q <= read_word;
          end
        end
        CTRL_WR: cnt <= (state_next == CTRL_WR) ? cnt + 3'd1 : 3'd0;
        default: cnt <= 3'd0;
      endcase
    end
  end

  assign if_ack    = (state == CTRL_DONE) && owner_if;
  assign mem_ack   = (state == CTRL_DONE) && !owner_if;
  assign if_inst   = if_inst_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = (state != CTRL_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and randomized bench for mem_ctrl against a byte-array reference of RAM contents.
module tb_mem_ctrl;

  localparam int          ADDR_W  = 17;
  localparam logic [31:0] MASK    = 32'h0001_FFFF;
  localparam int          TIMEOUT = 40;

  logic              clk, rst;
  logic              if_req, if_flush, if_ack;
  logic [31:0]       if_addr, if_inst;
  logic              mem_req, mem_we, mem_ack;
  logic [1:0]        mem_size;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout, ram_din;
  logic              ram_we, busy;
  logic [1:0]        dbg_state;

  bit   [7:0]        ram     [0:131071];
  bit   [7:0]        ref_mem [0:131071];
  logic              pre_we;
  logic [16:0]       pre_addr;
  logic [7:0]        pre_data;

  int                checks, errors;
  logic [31:0]       exp_q[$];
  logic [31:0]       last_if;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_ack(if_ack), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_we(ram_we), .ram_din(ram_din),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / RAM environment ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we)      ram[ram_addr] <= ram_dout;
    else if (pre_we) ram[pre_addr] <= pre_data;
    ram_din <= ram[ram_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model / checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[(a + 32'(k)) & MASK]) << (8 * k));
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [16:0] a;
    if ($urandom_range(0, 1) == 1) a = 17'($urandom_range(0, 496));
    else                           a = 17'(32'h1FF00 + $urandom_range(0, 255));
    return {15'($urandom), a};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a[16:0];
    pre_data = d;
    ref_mem[a & MASK] = d;
    @(negedge clk);
  endtask

  task automatic access(input bit is_if, input bit we_in, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int n, exp_cyc, cyc;
    bit got, we;
    logic [31:0] exp;
    we      = is_if ? 1'b0 : we_in;
    n       = is_if ? 4 : (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    exp_cyc = we ? n : n + 1;
    exp     = 32'h0;
    if (!we) exp_q.push_back(model_read(addr, n));
    @(negedge clk);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
    end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < TIMEOUT) begin
      @(negedge clk);
      if (cyc < n) begin
        check("ram_addr", 32'(ram_addr), (addr + 32'(cyc)) & MASK);
        check("ram_we", 32'(ram_we), 32'(we));
        if (we) check("ram_dout", 32'(ram_dout), (wdata >> (8 * cyc)) & 32'hFF);
      end
      if (is_if ? if_ack : mem_ack) got = 1'b1;
      else cyc++;
    end
    if_req  = 1'b0;
    mem_req = 1'b0;
    check(is_if ? "if_ack_seen" : "mem_ack_seen", 32'(got), 32'd1);
    check("ack_cycle", 32'(cyc), 32'(exp_cyc));
    check("other_ack", 32'(is_if ? mem_ack : if_ack), 32'd0);
    if (!we) begin
      exp = exp_q.pop_front();
      check(is_if ? "if_inst" : "mem_rdata", is_if ? if_inst : mem_rdata, exp);
      if (is_if) last_if = exp;
    end else begin
      for (int k = 0; k < n; k++) ref_mem[(addr + 32'(k)) & MASK] = wdata[8*k +: 8];
    end
    @(negedge clk);
    check("ack_width", 32'(is_if ? if_ack : mem_ack), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    if (we) begin
      for (int k = 0; k <= n; k++)
        check("ram_byte", 32'(ram[(addr + 32'(k)) & MASK]), 32'(ref_mem[(addr + 32'(k)) & MASK]));
    end
  endtask

  // ---------------- directed + random sequence ----------------
  logic [31:0] wd, exp_m, exp_i;
  int          cyc, m_cyc, i_cyc;
  bit          got, seen_if;

  initial begin
    checks = 0; errors = 0; last_if = 32'h0;
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
    pre_we = 1'b0; pre_addr = 17'h0; pre_data = 8'h0;
    repeat (3) @(negedge clk);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_if_ack", 32'(if_ack), 32'd0);
    check("rst_mem_ack", 32'(mem_ack), 32'd0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 512; i++) preload(32'(i), 8'($urandom));
    for (int i = 32'h1FF00; i < 32'h20000; i++) preload(32'(i), 8'($urandom));
    pre_we = 1'b0;

    // reset asserted during the third byte of a word store
    wd = $urandom;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h40; mem_wdata = wd;
    repeat (3) @(negedge clk);
    #1 check("wr_cycle2_we", 32'(ram_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_we", 32'(ram_we), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_mem_ack", 32'(mem_ack), 32'd0);
    check("rst_mid_if_ack", 32'(if_ack), 32'd0);
    mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ref_mem[32'h40] = wd[7:0];
    ref_mem[32'h41] = wd[15:8];
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      check("rst_partial_byte", 32'(ram[32'h40 + k]), 32'(ref_mem[32'h40 + k]));

    // fetch of a known instruction
    preload(32'h4, 8'h13); preload(32'h5, 8'h00); preload(32'h6, 8'h00); preload(32'h7, 8'h00);
    pre_we = 1'b0;
    access(1'b1, 1'b0, 2'b10, 32'h4, 32'h0);
    check("fetch_0x4", if_inst, 32'h0000_0013);

    // half load
    preload(32'h10, 8'h34); preload(32'h11, 8'h12);
    pre_we = 1'b0;
    access(1'b0, 1'b0, 2'b01, 32'h10, 32'h0);
    check("half_0x10", mem_rdata, 32'h0000_1234);

    // stores at the top of the address space
    access(1'b0, 1'b1, 2'b00, 32'h1FFFF, 32'hAABBCCDD);
    check("byte_top", 32'(ram[32'h1FFFF]), 32'hDD);
    access(1'b0, 1'b1, 2'b01, 32'h1FFFF, 32'hAABBCCDD);
    check("half_wrap", 32'(ram[0]), 32'hCC);

    // simultaneous IF and MEM request: MEM first
    exp_m = model_read(32'h100, 4);
    exp_i = model_read(32'h0, 4);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h100;
    cyc = 0; m_cyc = -1; i_cyc = -1;
    while ((m_cyc < 0 || i_cyc < 0) && cyc < TIMEOUT) begin
      @(negedge clk);
      if (mem_ack) begin
        m_cyc = cyc;
        check("tie_mem_rdata", mem_rdata, exp_m);
        mem_req = 1'b0;
      end
      if (if_ack) begin
        i_cyc = cyc;
        check("tie_if_inst", if_inst, exp_i);
        if_req = 1'b0;
      end
      cyc++;
    end
    if_req = 1'b0; mem_req = 1'b0;
    check("tie_mem_cycle", 32'(m_cyc), 32'd5);
    check("tie_if_cycle", 32'(i_cyc), 32'd12);
    last_if = exp_i;
    @(negedge clk);

    // flush during a fetch with a load pending (size 11 behaves as word)
    exp_m = model_read(32'h30, 4);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h20;
    repeat (3) @(negedge clk);
    if_flush = 1'b1; if_req = 1'b0;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b11; mem_addr = 32'h30;
    cyc = 3; got = 1'b0; seen_if = 1'b0;
    while (!got && cyc < TIMEOUT) begin
      @(negedge clk);
      if (cyc == 3) begin
        check("flush_idle", 32'(busy), 32'd0);
        if_flush = 1'b0;
      end
      if (if_ack) seen_if = 1'b1;
      if (mem_ack) got = 1'b1;
      else cyc++;
    end
    mem_req = 1'b0; if_flush = 1'b0;
    check("flush_mem_ack", 32'(got), 32'd1);
    check("flush_mem_cycle", 32'(cyc), 32'd9);
    check("flush_mem_rdata", mem_rdata, exp_m);
    check("flush_no_if_ack", 32'(seen_if), 32'd0);
    check("flush_if_inst_hold", if_inst, last_if);
    @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit          r_if, r_we;
      logic [1:0]  r_size;
      r_if   = ($urandom_range(0, 3) == 0);
      r_we   = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      access(r_if, r_we, r_size, rand_addr(), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
